// File: rtl/riscv_pkg.sv
// Shared RV64I integer-pipeline types: load funct3 encodings and write-back grant source.
package riscv_pkg;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LD  = 3'b011,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101,
      LD_LWU = 3'b110
   } ld_funct3_e;

   typedef enum logic {
      GRANT_ALU  = 1'b0,
      GRANT_LOAD = 1'b1
   } grant_t;

endpackage

// File: rtl/load_formatter.sv
// Aligns a raw memory doubleword to the addressed element and sign/zero extends it.
module load_formatter
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] raw,
   input  logic [2:0]            offset,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] fmt_data_c
);

   localparam int unsigned SHW = $clog2(DATA_WIDTH);

   logic [2:0]            eff_off;
   logic [DATA_WIDTH-1:0] shifted;
   ld_funct3_e            f3;

   always_comb begin
      f3         = ld_funct3_e'(funct3);
      eff_off    = 3'b000;
      shifted    = '0;
      fmt_data_c = '0;

      // Offset bits finer than the access size are ignored; LD and the illegal code use none.
      case (f3)
         LD_LB, LD_LBU: eff_off = offset;
         LD_LH, LD_LHU: eff_off = {offset[2:1], 1'b0};
         LD_LW, LD_LWU: eff_off = {offset[2], 2'b00};
         default:       eff_off = 3'b000;
      endcase

      shifted = raw >> SHW'({eff_off, 3'b000});

      case (f3)
         LD_LB:   fmt_data_c = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         LD_LH:   fmt_data_c = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         LD_LW:   fmt_data_c = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
         LD_LBU:  fmt_data_c = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         LD_LHU:  fmt_data_c = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         LD_LWU:  fmt_data_c = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
         default: fmt_data_c = shifted;
      endcase
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: merges ALU results and queued, formatted load results onto the
// single register-file write port with round-robin arbitration and a registered port.
module writeback_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned LQ_DEPTH   = 2
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic                          i_alu_valid,
   output logic                          o_alu_ready,
   input  logic [ADDR_WIDTH-1:0]         i_alu_rd,
   input  logic [DATA_WIDTH-1:0]         i_alu_data,
   input  logic                          i_ld_valid,
   output logic                          o_ld_ready,
   input  logic [ADDR_WIDTH-1:0]         i_ld_rd,
   input  logic [2:0]                    i_ld_funct3,
   input  logic [2:0]                    i_ld_offset,
   input  logic [DATA_WIDTH-1:0]         i_ld_raw,
   output logic                          o_write_en_3,
   output logic [ADDR_WIDTH-1:0]         o_addr_3,
   output logic [DATA_WIDTH-1:0]         o_write_data_3,
   output logic [$clog2(LQ_DEPTH):0]     o_ld_count
);

   localparam int unsigned PW = $clog2(LQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ADDR_WIDTH-1:0] lq_rd   [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] lq_data [LQ_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   grant_t                last_grant;

   logic                  write_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;

   logic [DATA_WIDTH-1:0] ld_fmt_c;
   logic                  fifo_empty_c;
   logic                  ld_ready_c;
   logic                  alu_ready_c;
   logic                  alu_fire_c;
   logic                  push_c;
   logic                  pop_c;

   load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
      .raw        (i_ld_raw),
      .offset     (i_ld_offset),
      .funct3     (i_ld_funct3),
      .fmt_data_c (ld_fmt_c)
   );

   // Handshakes depend only on registered state, never on a same-cycle pop or valid.
   always_comb begin
      fifo_empty_c = (count == '0);
      ld_ready_c   = (count != CW'(LQ_DEPTH));
      alu_ready_c  = fifo_empty_c || (last_grant == GRANT_LOAD);
      alu_fire_c   = i_alu_valid && alu_ready_c;
      push_c       = i_ld_valid && ld_ready_c;
      pop_c        = !alu_fire_c && !fifo_empty_c;
   end

   // Load queue storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge i_clk) begin
      if (push_c) begin
         lq_rd[wr_ptr]   <= i_ld_rd;
         lq_data[wr_ptr] <= ld_fmt_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Grant and registered write port; rd = x0 consumes the result without writing.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         write_en   <= 1'b0;
         addr       <= '0;
         write_data <= '0;
         last_grant <= GRANT_ALU;
      end else if (alu_fire_c) begin
         write_en   <= (i_alu_rd != '0);
         addr       <= i_alu_rd;
         write_data <= i_alu_data;
         last_grant <= GRANT_ALU;
      end else if (pop_c) begin
         write_en   <= (lq_rd[rd_ptr] != '0);
         addr       <= lq_rd[rd_ptr];
         write_data <= lq_data[rd_ptr];
         last_grant <= GRANT_LOAD;
      end else begin
         write_en   <= 1'b0;
      end
   end

   assign o_alu_ready    = alu_ready_c;
   assign o_ld_ready     = ld_ready_c;
   assign o_write_en_3   = write_en;
   assign o_addr_3       = addr;
   assign o_write_data_3 = write_data;
   assign o_ld_count     = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and scoreboard checks of the write-back arbiter (formatting, latency, alternation, reset).
module tb_writeback_arbiter;
   import riscv_pkg::*;

   localparam int unsigned DW  = 64;
   localparam int unsigned AW  = 5;
   localparam int unsigned LQD = 2;
   localparam int unsigned CW  = $clog2(LQD) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_rd;
   logic [2:0]    ld_funct3;
   logic [2:0]    ld_offset;
   logic [DW-1:0] ld_raw;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [CW-1:0] ld_count;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LQ_DEPTH(LQD)) dut (
      .i_clk          (clk),
      .i_arst_n       (rst_n),
      .i_alu_valid    (alu_valid),
      .o_alu_ready    (alu_ready),
      .i_alu_rd       (alu_rd),
      .i_alu_data     (alu_data),
      .i_ld_valid     (ld_valid),
      .o_ld_ready     (ld_ready),
      .i_ld_rd        (ld_rd),
      .i_ld_funct3    (ld_funct3),
      .i_ld_offset    (ld_offset),
      .i_ld_raw       (ld_raw),
      .o_write_en_3   (we),
      .o_addr_3       (waddr),
      .o_write_data_3 (wdata),
      .o_ld_count     (ld_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Element-select reference: picks the aligned byte/half/word directly.
   function automatic logic [63:0] ref_fmt(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] raw);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      int          bb;
      int          hb;
      int          wb;
      bb = int'(off);
      hb = int'(off) & 6;
      wb = int'(off) & 4;
      b  = raw[bb*8 +: 8];
      h  = raw[hb*8 +: 16];
      w  = raw[wb*8 +: 32];
      case (f3)
         3'd0:    ref_fmt = {{56{b[7]}}, b};
         3'd1:    ref_fmt = {{48{h[15]}}, h};
         3'd2:    ref_fmt = {{32{w[31]}}, w};
         3'd4:    ref_fmt = {56'd0, b};
         3'd5:    ref_fmt = {48'd0, h};
         3'd6:    ref_fmt = {32'd0, w};
         default: ref_fmt = raw;
      endcase
   endfunction

   typedef struct {
      logic [2:0]  f3;
      logic [2:0]  off;
      logic [63:0] raw;
      logic [4:0]  rd;
      logic [63:0] exp_data;
      logic        exp_we;
   } ld_vec_t;

   ld_vec_t     vec [14];
   logic        exp_ar  [6];
   logic        exp_lr  [6];
   logic [1:0]  exp_cnt [6];

   // Random-test scoreboard state
   logic [68:0]  ld_q [$];
   logic         alu_pend;
   logic [4:0]   alu_pend_rd;
   logic [63:0]  alu_pend_data;
   logic         alu_fired;
   logic         ld_fired;
   int unsigned  alu_acc;
   int unsigned  ld_acc;

   task automatic observe_write();
      logic [68:0] e;
      if (alu_pend) begin
         check("rnd_alu_we",   64'(we),    64'd1);
         check("rnd_alu_addr", 64'(waddr), 64'(alu_pend_rd));
         check("rnd_alu_data", wdata,      alu_pend_data);
         alu_pend = 1'b0;
      end else if (we) begin
         if (ld_q.size() == 0) begin
            check("rnd_unexpected_write", 64'(we), 64'd0);
         end else begin
            e = ld_q.pop_front();
            check("rnd_ld_addr", 64'(waddr), 64'(e[68:64]));
            check("rnd_ld_data", wdata,      e[63:0]);
         end
      end
   endtask

   initial begin
      vec[0]  = '{3'd0, 3'd1, 64'h0000_0000_0000_8000, 5'd7,  64'hFFFF_FFFF_FFFF_FF80, 1'b1};
      vec[1]  = '{3'd4, 3'd1, 64'h0000_0000_0000_8000, 5'd7,  64'h0000_0000_0000_0080, 1'b1};
      vec[2]  = '{3'd2, 3'd4, 64'h8765_4321_0000_0000, 5'd8,  64'hFFFF_FFFF_8765_4321, 1'b1};
      vec[3]  = '{3'd6, 3'd4, 64'h8765_4321_0000_0000, 5'd8,  64'h0000_0000_8765_4321, 1'b1};
      vec[4]  = '{3'd1, 3'd3, 64'h0000_0000_8001_0000, 5'd9,  64'hFFFF_FFFF_FFFF_8001, 1'b1};
      vec[5]  = '{3'd5, 3'd3, 64'h0000_0000_8001_0000, 5'd9,  64'h0000_0000_0000_8001, 1'b1};
      vec[6]  = '{3'd3, 3'd5, 64'h0123_4567_89AB_CDEF, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b1};
      vec[7]  = '{3'd7, 3'd3, 64'hFEDC_BA98_7654_3210, 5'd11, 64'hFEDC_BA98_7654_3210, 1'b1};
      vec[8]  = '{3'd0, 3'd7, 64'h7F00_0000_0000_0000, 5'd12, 64'h0000_0000_0000_007F, 1'b1};
      vec[9]  = '{3'd2, 3'd7, 64'h1234_5678_9ABC_DEF0, 5'd13, 64'h0000_0000_1234_5678, 1'b1};
      vec[10] = '{3'd6, 3'd2, 64'hFFFF_FFFF_8000_0000, 5'd14, 64'h0000_0000_8000_0000, 1'b1};
      vec[11] = '{3'd0, 3'd0, 64'h0000_0000_0000_00FF, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vec[12] = '{3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 5'd16, 64'h0000_0000_0000_BEEF, 1'b1};
      vec[13] = '{3'd0, 3'd0, 64'h0000_0000_0000_0055, 5'd0,  64'h0000_0000_0000_0055, 1'b0};

      exp_ar  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_lr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_cnt = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2};

      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_raw = '0;
      alu_pend = 1'b0; alu_pend_rd = '0; alu_pend_data = '0;
      alu_fired = 1'b0; ld_fired = 1'b0; alu_acc = 0; ld_acc = 0;

      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_we",        64'(we),        64'd0);
      check("rst_addr",      64'(waddr),     64'd0);
      check("rst_data",      wdata,          64'd0);
      check("rst_count",     64'(ld_count),  64'd0);
      check("rst_ld_ready",  64'(ld_ready),  64'd1);
      check("rst_alu_ready", 64'(alu_ready), 64'd1);

      // Single ALU result: write in N+1, low in N+2 with address/data held
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      #1 check("alu_ready", 64'(alu_ready), 64'd1);
      @(negedge clk);
      alu_valid = 1'b0;
      check("alu_we",   64'(we),    64'd1);
      check("alu_addr", 64'(waddr), 64'd5);
      check("alu_data", wdata,      64'h1234);
      @(negedge clk);
      check("alu_we_low",    64'(we),    64'd0);
      check("alu_addr_hold", 64'(waddr), 64'd5);
      check("alu_data_hold", wdata,      64'h1234);

      // Load formatting table: write appears two cycles after the handshake
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_funct3 = vec[i].f3; ld_offset = vec[i].off;
         ld_raw = vec[i].raw; ld_rd = vec[i].rd;
         #1 check($sformatf("fmt%0d_ld_ready", i), 64'(ld_ready), 64'd1);
         @(negedge clk);
         ld_valid = 1'b0;
         check($sformatf("fmt%0d_we_n1", i), 64'(we),       64'd0);
         check($sformatf("fmt%0d_count", i), 64'(ld_count), 64'd1);
         @(negedge clk);
         check($sformatf("fmt%0d_we", i),       64'(we),       64'(vec[i].exp_we));
         check($sformatf("fmt%0d_count_0", i),  64'(ld_count), 64'd0);
         if (vec[i].exp_we) begin
            check($sformatf("fmt%0d_addr", i), 64'(waddr), 64'(vec[i].rd));
            check($sformatf("fmt%0d_data", i), wdata,      vec[i].exp_data);
         end
      end

      // ALU to x0: handshake completes, no write
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
      #1 check("alu_x0_ready", 64'(alu_ready), 64'd1);
      @(negedge clk);
      alu_valid = 1'b0;
      check("alu_x0_we", 64'(we), 64'd0);

      // Continuous contention: strict alternation and FIFO fill to full
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'd3; ld_offset = 3'd0; ld_raw = 64'hB;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check($sformatf("cont%0d_alu_ready", k), 64'(alu_ready), 64'(exp_ar[k]));
         check($sformatf("cont%0d_ld_ready", k),  64'(ld_ready),  64'(exp_lr[k]));
         check($sformatf("cont%0d_count", k),     64'(ld_count),  64'(exp_cnt[k]));
         if (k > 0) begin
            check($sformatf("cont%0d_we", k),   64'(we),    64'd1);
            check($sformatf("cont%0d_addr", k), 64'(waddr), (k % 2 == 1) ? 64'd3 : 64'd4);
            check($sformatf("cont%0d_data", k), wdata,      (k % 2 == 1) ? 64'hA : 64'hB);
         end
      end

      // Reset asserted with two loads queued
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",    64'(we),       64'd0);
      check("mid_rst_addr",  64'(waddr),    64'd0);
      check("mid_rst_data",  wdata,         64'd0);
      check("mid_rst_count", 64'(ld_count), 64'd0);
      alu_valid = 1'b0; ld_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d_we", k), 64'(we), 64'd0);
      end
      check("post_rst_count", 64'(ld_count), 64'd0);

      // Random traffic against the scoreboard
      for (int cyc = 0; cyc < 3000 && (alu_acc + ld_acc) < 100; cyc++) begin
         @(negedge clk);
         observe_write();
         if (alu_fired) alu_valid = 1'b0;
         if (ld_fired)  ld_valid  = 1'b0;
         if (!alu_valid && $urandom_range(0, 3) != 0) begin
            alu_valid = 1'b1;
            alu_rd    = 5'($urandom_range(1, 31));
            alu_data  = {$urandom, $urandom};
         end
         if (!ld_valid && $urandom_range(0, 3) != 0) begin
            ld_valid  = 1'b1;
            ld_rd     = 5'($urandom_range(1, 31));
            ld_funct3 = 3'($urandom_range(0, 7));
            ld_offset = 3'($urandom_range(0, 7));
            ld_raw    = {$urandom, $urandom};
         end
         #1;
         alu_fired = alu_valid && alu_ready;
         ld_fired  = ld_valid && ld_ready;
         if (alu_fired) begin
            alu_pend = 1'b1; alu_pend_rd = alu_rd; alu_pend_data = alu_data; alu_acc++;
         end
         if (ld_fired) begin
            ld_q.push_back({ld_rd, ref_fmt(ld_funct3, ld_offset, ld_raw)});
            ld_acc++;
         end
      end
      for (int d = 0; d < 8; d++) begin
         @(negedge clk);
         alu_valid = 1'b0; ld_valid = 1'b0;
         alu_fired = 1'b0; ld_fired = 1'b0;
         observe_write();
      end
      check("rnd_budget",     64'((alu_acc + ld_acc) >= 100), 64'd1);
      check("rnd_ld_drained", 64'(ld_q.size()),               64'd0);
      check("rnd_alu_drained", 64'(alu_pend),                 64'd0);
      check("rnd_count_end",  64'(ld_count),                  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
